// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared segment encodings, monitor state type and BCD helper
//               for the seven-segment sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_6_ALT = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Successor in the 0..9 wrap-around count
    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_sequence_monitor_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational seven-segment to BCD decoder. Flags legal
//               digits and the blank pattern; anything else is invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank
);

    // Map each legal pattern (including the alternate 6 and 9) to its digit
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (segments)
            SEG_0:                digit = 4'd0;
            SEG_1:                digit = 4'd1;
            SEG_2:                digit = 4'd2;
            SEG_3:                digit = 4'd3;
            SEG_4:                digit = 4'd4;
            SEG_5:                digit = 4'd5;
            SEG_6, SEG_6_ALT:     digit = 4'd6;
            SEG_7:                digit = 4'd7;
            SEG_8:                digit = 4'd8;
            SEG_9, SEG_9_ALT:     digit = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:              is_digit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seg7_sequence_monitor
// Description : Glitch-filters a sampled seven-segment bus, decodes stable
//               patterns and checks they follow the 0..9 wrap-around count.
//               Reports digit, lock, step/error pulses and a saturating
//               error count. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_sequence_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           segments,
    output logic [3:0]           digit,
    output logic                 valid,
    output logic                 locked,
    output logic                 step,
    output logic                 error,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

    logic [6:0]           r_cand;
    logic [7:0]           r_count;
    logic                 w_accept;

    logic [3:0]           w_dec_digit;
    logic                 w_is_digit;
    logic                 w_is_blank;

    state_t               r_state;
    state_t               w_state_next;

    logic [3:0]           r_digit;
    logic                 r_valid;
    logic                 r_step;
    logic                 r_error;
    logic [ERR_WIDTH-1:0] r_err_count;

    logic [3:0]           w_digit_next;
    logic                 w_valid_next;
    logic                 w_step_next;
    logic                 w_error_next;

    // Decode the live bus; on an accept edge it equals the candidate
    seg7_decode u_decode (
        .segments (segments),
        .digit    (w_dec_digit),
        .is_digit (w_is_digit),
        .is_blank (w_is_blank)
    );

    // Accept fires once, on the edge where the run length reaches STABLE_CYCLES
    assign w_accept = (segments == r_cand) && (r_count == (C_STABLE - 8'd1));

    // Stability filter: restart the run on any change, saturate at the target
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand  <= SEG_BLANK;
            r_count <= 8'd0;
        end else if (segments != r_cand) begin
            r_cand  <= segments;
            r_count <= 8'd1;
        end else if (r_count < C_STABLE) begin
            r_count <= r_count + 8'd1;
        end
    end

    // State register plus registered outputs and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SYNC;
            r_digit     <= 4'd0;
            r_valid     <= 1'b0;
            r_step      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_digit <= w_digit_next;
            r_valid <= w_valid_next;
            r_step  <= w_step_next;
            r_error <= w_error_next;
            if (w_error_next && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERR_WIDTH'(1);
            end
        end
    end

    // Next state: lock on a digit, drop to SYNC on blank or invalid
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                SYNC:    if (w_is_digit) w_state_next = TRACK;
                TRACK:   if (!w_is_digit) w_state_next = SYNC;
                default: w_state_next = SYNC;
            endcase
        end
    end

    // Output decisions for an accepted pattern; pulses default low
    always_comb begin
        w_digit_next = r_digit;
        w_valid_next = r_valid;
        w_step_next  = 1'b0;
        w_error_next = 1'b0;
        if (w_accept) begin
            case (r_state)
                SYNC: begin
                    if (w_is_digit) begin
                        w_digit_next = w_dec_digit;
                        w_valid_next = 1'b1;
                    end else if (!w_is_blank) begin
                        w_error_next = 1'b1;
                    end
                end
                TRACK: begin
                    if (w_is_digit) begin
                        if (w_dec_digit == bcd_next(r_digit)) begin
                            w_step_next  = 1'b1;
                            w_digit_next = w_dec_digit;
                        end else if (w_dec_digit != r_digit) begin
                            // Out-of-order digit: flag it and resync to it
                            w_error_next = 1'b1;
                            w_digit_next = w_dec_digit;
                        end
                    end else if (!w_is_blank) begin
                        w_error_next = 1'b1;
                        w_valid_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digit     = r_digit;
    assign valid     = r_valid;
    assign locked    = (r_state == TRACK);
    assign step      = r_step;
    assign error     = r_error;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_seg7_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_sequence_monitor
// Description : Self-checking bench for seg7_sequence_monitor. A run-length
//               model predicts every output each cycle; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_sequence_monitor;

    localparam int S    = 4;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    segments = 7'h00;
    logic [3:0]    digit;
    logic          valid;
    logic          locked;
    logic          step;
    logic          error;
    logic [EW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_sequence_monitor #(
        .STABLE_CYCLES (S),
        .ERR_WIDTH     (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .segments  (segments),
        .digit     (digit),
        .valid     (valid),
        .locked    (locked),
        .step      (step),
        .error     (error),
        .err_count (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decoded value of a pattern: 0..9, -1 for blank, -2 for invalid
    function automatic int dec(input logic [6:0] s);
        case (s)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D, 7'h7C: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F, 7'h67: return 9;
            7'h00: return -1;
            default: return -2;
        endcase
    endfunction

    // Inputs as seen by the DUT at each rising edge
    logic [6:0] smp_seg;
    logic       smp_rst;
    bit         smp_valid = 1'b0;
    always @(posedge clk) begin
        smp_seg   <= segments;
        smp_rst   <= reset;
        smp_valid <= 1'b1;
    end

    // Model: run length of the current pattern, digit/lock bookkeeping
    int         m_run;
    logic [6:0] m_last;
    int         m_digit;
    int         m_valid, m_locked, m_step, m_error, m_err;
    bit         m_init = 1'b0;
    int         n_step = 0;
    int         n_err  = 0;

    task automatic model_step(input logic [6:0] s, input logic r);
        int d;
        if (r) begin
            m_init = 1'b1;
            m_run = 0; m_last = 7'h00;
            m_digit = 0; m_valid = 0; m_locked = 0;
            m_step = 0; m_error = 0; m_err = 0;
            return;
        end
        m_step  = 0;
        m_error = 0;
        if (s == m_last) m_run = m_run + 1;
        else begin
            m_last = s;
            m_run  = 1;
        end
        if (m_run == S) begin
            d = dec(s);
            if (m_locked == 0) begin
                if (d >= 0) begin
                    m_digit = d; m_valid = 1; m_locked = 1;
                end else if (d == -2) m_error = 1;
            end else begin
                if (d >= 0) begin
                    if (d == (m_digit + 1) % 10) m_step = 1;
                    else if (d != m_digit) m_error = 1;
                    m_digit = d;
                end else if (d == -1) begin
                    m_locked = 0;
                end else begin
                    m_error = 1; m_locked = 0; m_valid = 0;
                end
            end
            if (m_error == 1 && m_err < EMAX) m_err = m_err + 1;
        end
    endtask

    // Compare process: advance the model and check every output each cycle
    always @(negedge clk) begin
        if (smp_valid) model_step(smp_seg, smp_rst);
        if (m_init) begin
            check("digit",     digit,     m_digit);
            check("valid",     valid,     m_valid);
            check("locked",    locked,    m_locked);
            check("step",      step,      m_step);
            check("error",     error,     m_error);
            check("err_count", err_count, m_err);
            if (step === 1'b1 && error === 1'b1) check("step_and_error", 1, 0);
            if (step === 1'b1)  n_step++;
            if (error === 1'b1) n_err++;
        end
    end

    task automatic hold(input logic [6:0] s, input int n);
        segments = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pats [10];
        int s0, e0;
        pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        // Reset state
        reset = 1'b1; segments = 7'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_digit",  digit, 0);
        check("rst_valid",  valid, 0);
        check("rst_locked", locked, 0);
        check("rst_errcnt", err_count, 0);

        // Full count 0..9,0
        s0 = n_step; e0 = n_err;
        hold(pats[0], 10);
        check("full_lock", locked, 1);
        check("full_lock_nostep", n_step - s0, 0);
        for (int i = 1; i < 10; i++) hold(pats[i], 10);
        hold(pats[0], 10);
        check("full_steps",  n_step - s0, 10);
        check("full_digit",  digit, 0);
        check("full_errcnt", err_count, 0);
        check("full_errs",   n_err - e0, 0);

        // Glitch rejection
        hold(7'h06, 10); hold(7'h5B, 10); hold(7'h4F, 10);
        s0 = n_step; e0 = n_err;
        hold(7'h7F, 3);
        hold(7'h4F, 10);
        check("glitch_nostep", n_step - s0, 0);
        hold(7'h66, 10);
        check("glitch_step",  n_step - s0, 1);
        check("glitch_noerr", n_err - e0, 0);
        check("glitch_digit", digit, 4);

        // Skip 3 -> 5
        hold(7'h00, 10);
        check("blank_unlock", locked, 0);
        check("blank_keep_valid", valid, 1);
        check("blank_keep_digit", digit, 4);
        hold(7'h4F, 10);
        check("relock3_digit", digit, 3);
        s0 = n_step;
        hold(7'h6D, 10);
        check("skip_errcnt", err_count, 1);
        check("skip_digit",  digit, 5);
        check("skip_locked", locked, 1);
        check("skip_nostep", n_step - s0, 0);
        hold(7'h7C, 10);
        check("skip_then_step", n_step - s0, 1);
        check("alt6_digit", digit, 6);

        // Invalid and blank
        hold(7'h00, 10);
        hold(7'h5B, 10);
        e0 = n_err;
        hold(7'h49, 10);
        check("inv_err",    n_err - e0, 1);
        check("inv_locked", locked, 0);
        check("inv_valid",  valid, 0);
        check("inv_digit",  digit, 2);
        check("inv_errcnt", err_count, 2);
        e0 = n_err; s0 = n_step;
        hold(7'h00, 10);
        hold(7'h07, 10);
        check("relock7_digit", digit, 7);
        check("relock7_lock",  locked, 1);
        check("relock7_valid", valid, 1);
        check("relock7_nostep", n_step - s0, 0);
        check("relock7_noerr",  n_err - e0, 0);

        // Saturation
        segments = 7'h00; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("sat_start", err_count, 0);
        e0 = n_err;
        for (int i = 0; i < 20; i++) begin
            hold(7'h49, 6);
            hold(7'h00, 6);
        end
        check("sat_pulses", n_err - e0, 20);
        check("sat_errcnt", err_count, 15);
        check("sat_locked", locked, 0);

        // Reset on the edge an accept would fire
        segments = 7'h06;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2_valid",  valid, 0);
        check("rst2_locked", locked, 0);
        check("rst2_errcnt", err_count, 0);
        check("rst2_step",   step, 0);
        check("rst2_error",  error, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst2_not_yet", valid, 0);
        @(negedge clk);
        #1;
        check("rst2_accept_valid", valid, 1);
        check("rst2_accept_digit", digit, 1);
        check("rst2_accept_lock",  locked, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
